apb_bus_arbiter: RTL

Round-robin APB master that shares the single APB bus to the POLI register slave between NREQ on-chip requesters. It takes the winning requester's read or write and runs the APB SETUP/ACCESS sequence. It returns read data and a completion pulse to that requester. A PREADY timeout guarantees the bus never locks up. It sits between the requester blocks and the APB slave; its APB outputs drive the slave directly.

---
 rtl/apb_bus_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/apb_bus_arbiter.sv
// Round-robin APB master: shares one APB bus among NREQ requesters, runs
// the SETUP/ACCESS handshake and bounds every transfer with a PREADY timeout.
module apb_bus_arbiter #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          ack,
  output logic                     err,
  output logic [DATA_W-1:0]        rdata,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [ADDR_W-1:0]        PADDR,
  output logic [DATA_W-1:0]        PWDATA,
  input  logic [DATA_W-1:0]        PRDATA,
  input  logic                     PREADY
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [IDX_W-1:0]  winner_q, winner_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [ADDR_W-1:0] addr_arr  [NREQ];
  logic [DATA_W-1:0] wdata_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Rotating priority scan; a requester being acked this cycle is excluded
  // so its still-high req is not mistaken for a new request.
  logic             found;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(last_grant_q) + k) % NREQ);
      if (!found && req[cand] && !ack_q[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    wait_d       = wait_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    ack_d        = '0;
    err_d        = 1'b0;
    rdata_d      = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          pwrite_d     = req_write[pick];
          paddr_d      = addr_arr[pick];
          pwdata_d     = wdata_arr[pick];
          winner_d     = pick;
          last_grant_d = pick;
          psel_d       = 1'b1;
          penable_d    = 1'b0;
          state_d      = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        wait_d    = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          ack_d[winner_q] = 1'b1;
          rdata_d         = pwrite_q ? '0 : PRDATA;
          psel_d          = 1'b0;
          penable_d       = 1'b0;
          state_d         = S_IDLE;
        end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
          ack_d[winner_q] = 1'b1;
          err_d           = 1'b1;
          rdata_d         = '0;
          psel_d          = 1'b0;
          penable_d       = 1'b0;
          state_d         = S_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= S_IDLE;
      last_grant_q <= IDX_W'(NREQ - 1);
      winner_q     <= '0;
      wait_q       <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      ack_q        <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      wait_q       <= wait_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign ack     = ack_q;
  assign err     = err_q;
  assign rdata   = rdata_q;

endmodule
